comp_div: RTL and testbench

- Sequential complex divider: q = a / b = a·conj(b) / |b|², for signed 8-bit complex operands.
- It is the inverse-operation companion to the team's two-cycle complex multiplier and uses the same operand format and i_en-style start.
- One restoring divider is shared between the real and imaginary parts; the real part is computed first, then the imaginary part.
- Result is signed fixed-point with FRAC fractional bits, truncated toward zero.

---
 rtl/comp_div.sv | 253 +++++++++++++++++++++++++
 tb/tb_comp_div.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/comp_div.sv
// -----------------------------------------------------------------------------
// comp_div -- sequential complex divider, q = a / b = a*conj(b) / |b|^2.
//
// Operands are signed 8-bit complex values. The numerator parts
//   num_r = a_r*b_r + a_i*b_i
//   num_i = a_i*b_r - a_r*b_i
// and den = b_r^2 + b_i^2 are formed in one SETUP cycle. A single restoring
// divider then produces |num_r|<<FRAC / den followed by |num_i|<<FRAC / den,
// one quotient bit per cycle, MSB first. The sign is applied to the truncated
// magnitude, so rounding is toward zero.
//
// Latency from the i_en sampling edge (edge 0): o_valid is high after edge
// 2N+2 (N = 16+FRAC), or after edge 2 when b = 0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   a_r,a_i  in   signed 8-bit dividend (real, imaginary)
//   b_r,b_i  in   signed 8-bit divisor  (real, imaginary)
//   i_en     in   start strobe, sampled only in IDLE
//   busy     out  high in every state except IDLE
//   o_valid  out  one-cycle pulse when q_r/q_i/div0 update
//   div0     out  set with o_valid when b = 0, cleared at the next start
//   q_r,q_i  out  signed quotient, 17+FRAC bits, FRAC fractional bits
// -----------------------------------------------------------------------------
module comp_div #(
  parameter int FRAC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [7:0]        a_r,
  input  logic signed [7:0]        a_i,
  input  logic signed [7:0]        b_r,
  input  logic signed [7:0]        b_i,
  input  logic                     i_en,
  output logic                     busy,
  output logic                     o_valid,
  output logic                     div0,
  output logic signed [16+FRAC:0]  q_r,
  output logic signed [16+FRAC:0]  q_i
);

  localparam int N  = 16 + FRAC;   // quotient magnitude bits / divide steps
  localparam int QW = 17 + FRAC;   // signed output width
  localparam int CW = $clog2(N);   // step counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DIV_R,
    S_DIV_I,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Registered operands.
  logic signed [7:0] r_a_r, r_a_i, r_b_r, r_b_i;

  // Registered SETUP results. The real magnitude goes straight into the
  // divider's shift register, so only its sign is kept separately.
  logic              r_neg_r, r_neg_i;
  logic [15:0]       r_mag_i;
  logic [15:0]       r_den;

  // Divider state. r_dvd shifts the dividend out at the top and the quotient
  // bits in at the bottom; after N steps it holds the full quotient.
  logic [N-1:0]      r_dvd;
  logic [15:0]       r_rem;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_quo_r;

  // Output registers.
  logic              r_valid;
  logic              r_div0;
  logic [QW-1:0]     r_q_r, r_q_i;

  // ---------------------------------------------------------------------------
  // SETUP arithmetic (from the registered operands)
  // ---------------------------------------------------------------------------
  logic signed [16:0] w_p_rr, w_p_ii, w_p_ir, w_p_ri;
  logic signed [16:0] w_num_r, w_num_i;
  logic [15:0]        w_mag_r, w_mag_i;
  logic [7:0]         w_abs_br, w_abs_bi;
  logic [15:0]        w_den;

  assign w_p_rr  = r_a_r * r_b_r;
  assign w_p_ii  = r_a_i * r_b_i;
  assign w_p_ir  = r_a_i * r_b_r;
  assign w_p_ri  = r_a_r * r_b_i;
  assign w_num_r = w_p_rr + w_p_ii;
  assign w_num_i = w_p_ir - w_p_ri;

  // |num| never exceeds 32768, so the low 16 bits of the two's complement
  // negation are the exact unsigned magnitude (including -32768 -> 0x8000).
  assign w_mag_r = w_num_r[16] ? (~w_num_r[15:0] + 16'd1) : w_num_r[15:0];
  assign w_mag_i = w_num_i[16] ? (~w_num_i[15:0] + 16'd1) : w_num_i[15:0];

  // Squares via unsigned magnitudes: 128^2 + 128^2 = 32768 fits in 16 bits.
  assign w_abs_br = r_b_r[7] ? (~r_b_r[7:0] + 8'd1) : r_b_r[7:0];
  assign w_abs_bi = r_b_i[7] ? (~r_b_i[7:0] + 8'd1) : r_b_i[7:0];
  assign w_den    = w_abs_br * w_abs_br + w_abs_bi * w_abs_bi;

  // ---------------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------------
  logic [16:0]  w_trial;
  logic [16:0]  w_diff;
  logic         w_ge;
  logic [15:0]  w_rem_nx;
  logic [N-1:0] w_dvd_nx;
  logic         w_last;

  // The remainder stays below den <= 32768, so the trial value stays below
  // 2^16 and bit 16 of the difference is a clean borrow flag.
  assign w_trial  = {r_rem, r_dvd[N-1]};
  assign w_diff   = w_trial - {1'b0, r_den};
  assign w_ge     = ~w_diff[16];
  assign w_rem_nx = w_ge ? w_diff[15:0] : w_trial[15:0];
  assign w_dvd_nx = {r_dvd[N-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(N - 1));

  // Sign application on the truncated magnitudes.
  logic [QW-1:0] w_qr_mag, w_qi_mag;

  assign w_qr_mag = {1'b0, r_quo_r};
  assign w_qi_mag = {1'b0, r_dvd};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on paths that do not change the state.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_en) w_state_nx = S_SETUP;
      S_SETUP: w_state_nx = (w_den == 16'd0) ? S_DONE : S_DIV_R;
      S_DIV_R: if (w_last) w_state_nx = S_DIV_I;
      S_DIV_I: if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_r   <= '0;
      r_a_i   <= '0;
      r_b_r   <= '0;
      r_b_i   <= '0;
      r_neg_r <= 1'b0;
      r_neg_i <= 1'b0;
      r_mag_i <= '0;
      r_den   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_quo_r <= '0;
      r_valid <= 1'b0;
      r_div0  <= 1'b0;
      r_q_r   <= '0;
      r_q_i   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_a_r  <= a_r;
            r_a_i  <= a_i;
            r_b_r  <= b_r;
            r_b_i  <= b_i;
            r_div0 <= 1'b0;
          end
        end

        S_SETUP: begin
          r_neg_r <= w_num_r[16];
          r_neg_i <= w_num_i[16];
          r_mag_i <= w_mag_i;
          r_den   <= w_den;
          r_dvd   <= {w_mag_r, {FRAC{1'b0}}};
          r_rem   <= '0;
          r_cnt   <= '0;
        end

        S_DIV_R: begin
          if (w_last) begin
            // Real quotient complete; reload the divider for the imaginary part.
            r_quo_r <= w_dvd_nx;
            r_dvd   <= {r_mag_i, {FRAC{1'b0}}};
            r_rem   <= '0;
            r_cnt   <= '0;
          end else begin
            r_dvd   <= w_dvd_nx;
            r_rem   <= w_rem_nx;
            r_cnt   <= r_cnt + CW'(1);
          end
        end

        S_DIV_I: begin
          r_dvd <= w_dvd_nx;
          r_rem <= w_rem_nx;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end

        S_DONE: begin
          r_valid <= 1'b1;
          if (r_den == 16'd0) begin
            r_q_r  <= '0;
            r_q_i  <= '0;
            r_div0 <= 1'b1;
          end else begin
            r_q_r  <= r_neg_r ? -w_qr_mag : w_qr_mag;
            r_q_i  <= r_neg_i ? -w_qi_mag : w_qi_mag;
          end
        end

        default: ;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign div0    = r_div0;
  assign q_r     = r_q_r;
  assign q_i     = r_q_i;

endmodule

// File: tb/tb_comp_div.sv
// -----------------------------------------------------------------------------
// tb_comp_div -- self-checking bench for comp_div.
// Directed corner cases plus random operands, each compared against a
// reference computed with plain integer complex arithmetic.
// -----------------------------------------------------------------------------
module tb_comp_div;

  localparam int FRAC = 8;
  localparam int N    = 16 + FRAC;
  localparam int QW   = 17 + FRAC;
  localparam int MAXC = 200;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic signed [7:0]     a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic                  i_en = 1'b0;
  logic                  busy, o_valid, div0;
  logic signed [QW-1:0]  q_r, q_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  comp_div #(.FRAC(FRAC)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_r     (a_r),
    .a_i     (a_i),
    .b_r     (b_r),
    .b_i     (b_i),
    .i_en    (i_en),
    .busy    (busy),
    .o_valid (o_valid),
    .div0    (div0),
    .q_r     (q_r),
    .q_i     (q_i)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: q = a*conj(b)/|b|^2 scaled by 2^FRAC, truncated toward zero.
  task automatic model(input int ar, input int ai, input int br, input int bi,
                       output longint qr, output longint qi, output bit d0,
                       output int lat);
    longint nr, ni, den;
    nr  = longint'(ar) * br + longint'(ai) * bi;
    ni  = longint'(ai) * br - longint'(ar) * bi;
    den = longint'(br) * br + longint'(bi) * bi;
    if (den == 0) begin
      qr = 0; qi = 0; d0 = 1'b1; lat = 2;
    end else begin
      qr = (nr * (64'sd1 <<< FRAC)) / den;
      qi = (ni * (64'sd1 <<< FRAC)) / den;
      d0 = 1'b0; lat = 2 * N + 2;
    end
  endtask

  function automatic logic signed [7:0] sb(input int v);
    return v[7:0];
  endfunction

  // Present operands and pulse i_en; returns #1 after the sampling edge.
  task automatic start(input int ar, input int ai, input int br, input int bi);
    @(negedge clk);
    a_r = sb(ar); a_i = sb(ai); b_r = sb(br); b_i = sb(bi);
    i_en = 1'b1;
    @(posedge clk);
    #1 i_en = 1'b0;
  endtask

  // Waits for o_valid; 'elapsed' is the number of edges already past edge 0.
  task automatic wait_result(input string tag, input int elapsed,
                             input int ar, input int ai, input int br, input int bi);
    longint eqr, eqi;
    bit     ed0;
    int     lat, cyc;
    bit     busy_ok, seen;
    model(ar, ai, br, bi, eqr, eqi, ed0, lat);
    cyc = elapsed; busy_ok = 1'b1; seen = 1'b0;
    while (cyc < MAXC && !seen) begin
      @(posedge clk);
      #1 cyc++;
      if (o_valid) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy_during"}, busy_ok, 1);
    check({tag, " busy_at_valid"}, busy, 0);
    check({tag, " q_r"}, q_r, eqr);
    check({tag, " q_i"}, q_i, eqi);
    check({tag, " div0"}, div0, ed0);
    @(posedge clk);
    #1 check({tag, " valid_pulse"}, o_valid, 0);
  endtask

  task automatic run_op(input string tag, input int ar, input int ai,
                        input int br, input int bi);
    start(ar, ai, br, bi);
    wait_result(tag, 0, ar, ai, br, bi);
  endtask

  initial begin
    int vals [4];
    int pulses;

    // Reset state.
    #12;
    check("rst busy", busy, 0);
    check("rst o_valid", o_valid, 0);
    check("rst div0", div0, 0);
    check("rst q_r", q_r, 0);
    check("rst q_i", q_i, 0);
    @(negedge clk) rst = 1'b1;

    // Directed cases.
    run_op("4/2",        4,    0,    2,    0);
    run_op("(1+j)/(1-j)", 1,    1,    1,   -1);
    run_op("1/3",        1,    0,    3,    0);
    run_op("-1/3",      -1,    0,    3,    0);
    run_op("max/max", -128, -128, -128, -128);
    run_op("x/j",      127, -128,    0,    1);
    run_op("b0",         5,    5,    0,    0);
    run_op("after_b0",   7,   -3,    2,    5);
    run_op("min/1",   -128,    0,    1,    0);

    // i_en during busy with different operands must be ignored.
    start(10, -20, 3, 4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    a_r = sb(-99); a_i = sb(55); b_r = sb(0); b_i = sb(0);
    i_en = 1'b1;
    @(posedge clk);
    #1 i_en = 1'b0;
    wait_result("ignore_en", 6, 10, -20, 3, 4);

    // Asynchronous reset in the middle of a division.
    start(100, -50, 7, -3);
    repeat (19) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst o_valid", o_valid, 0);
    check("midrst q_r", q_r, 0);
    check("midrst q_i", q_i, 0);
    check("midrst div0", div0, 0);
    pulses = 0;
    repeat (2 * N + 6) begin
      @(posedge clk);
      #1 if (o_valid) pulses++;
    end
    check("midrst no_valid", pulses, 0);
    @(negedge clk) rst = 1'b1;
    run_op("restart", 100, -50, 7, -3);

    // Random operands.
    for (int k = 0; k < 30; k++) begin
      for (int j = 0; j < 4; j++) vals[j] = int'($urandom_range(0, 255)) - 128;
      if (k % 10 == 9) begin
        vals[2] = 0; vals[3] = 0;
      end
      run_op($sformatf("rand%0d", k), vals[0], vals[1], vals[2], vals[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
